// File: rtl/rpc_dqs_calib_ctrl.sv
// rpc_dqs_calib_ctrl: sweeps the RPC PHY DQS read-capture delay taps,
// runs one training read per tap and centres on the longest passing window.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   start_i, expected_i     calibration start pulse and training pattern
//   trn_req_o/ack_i/data_i  training-read handshake to the RPC controller
//   delay_cfg_o             tap code to the PHY delay line
//   busy_o, done_o, error_o status levels
//   win_lo_o, win_hi_o      bounds of the best passing window
module rpc_dqs_calib_ctrl #(
  parameter int DELAY_CFG_WIDTH = 5,
  parameter int PATTERN_WIDTH   = 32,
  parameter int SETTLE_CYCLES   = 8,
  parameter int TIMEOUT_CYCLES  = 1024,
  parameter int DEFAULT_TAP     = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic [PATTERN_WIDTH-1:0]   expected_i,
  output logic                       trn_req_o,
  input  logic                       trn_ack_i,
  input  logic [PATTERN_WIDTH-1:0]   trn_data_i,
  output logic [DELAY_CFG_WIDTH-1:0] delay_cfg_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       error_o,
  output logic [DELAY_CFG_WIDTH-1:0] win_lo_o,
  output logic [DELAY_CFG_WIDTH-1:0] win_hi_o
);

  localparam int W  = DELAY_CFG_WIDTH;
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SET    = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_REQ    = 3'd3;
  localparam logic [2:0] S_EVAL   = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;

  localparam logic [W-1:0]  TAP_MAX  = '1;
  localparam logic [W-1:0]  TAP_DEF  = W'(DEFAULT_TAP);
  localparam logic [W-1:0]  TAP_ONE  = W'(1);
  localparam logic [W:0]    LEN_ONE  = (W+1)'(1);
  localparam logic [SW-1:0] SET_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  logic [2:0]               state;
  logic [W-1:0]             tap;
  logic [SW-1:0]            settle_cnt;
  logic [TW-1:0]            to_cnt;
  logic [PATTERN_WIDTH-1:0] exp_q;
  logic                     pass;
  logic [W:0]               cur_len;
  logic [W:0]               best_len;
  logic [W-1:0]             cur_start;
  logic [W-1:0]             best_start;

  logic [W:0]   len_inc;
  logic [W-1:0] run_start;
  logic [W-1:0] hi_c;
  logic [W:0]   sum_c;

  assign len_inc   = cur_len + LEN_ONE;
  assign run_start = (cur_len == '0) ? tap : cur_start;
  // best_len == 2^W truncates to 0 here; the modular -1 still lands on TAP_MAX
  assign hi_c      = best_start + best_len[W-1:0] - TAP_ONE;
  assign sum_c     = {1'b0, best_start} + {1'b0, hi_c};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      tap         <= '0;
      settle_cnt  <= '0;
      to_cnt      <= '0;
      exp_q       <= '0;
      pass        <= 1'b0;
      cur_len     <= '0;
      best_len    <= '0;
      cur_start   <= '0;
      best_start  <= '0;
      trn_req_o   <= 1'b0;
      delay_cfg_o <= TAP_DEF;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      error_o     <= 1'b0;
      win_lo_o    <= '0;
      win_hi_o    <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start_i) begin
            exp_q      <= expected_i;
            done_o     <= 1'b0;
            error_o    <= 1'b0;
            cur_len    <= '0;
            best_len   <= '0;
            cur_start  <= '0;
            best_start <= '0;
            tap        <= '0;
            busy_o     <= 1'b1;
            state      <= S_SET;
          end
        end
        S_SET: begin
          delay_cfg_o <= tap;
          settle_cnt  <= '0;
          state       <= S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_cnt == SET_LAST) begin
            trn_req_o <= 1'b1;
            to_cnt    <= '0;
            state     <= S_REQ;
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end
        S_REQ: begin
          if (trn_ack_i) begin
            trn_req_o <= 1'b0;
            pass      <= (trn_data_i == exp_q);
            state     <= S_EVAL;
          end else if (to_cnt == TO_LAST) begin
            // a timeout discards any window found so far
            trn_req_o <= 1'b0;
            best_len  <= '0;
            state     <= S_FINISH;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        S_EVAL: begin
          if (pass) begin
            cur_start <= run_start;
            cur_len   <= len_inc;
            if (len_inc > best_len) begin
              best_start <= run_start;
              best_len   <= len_inc;
            end
          end else begin
            cur_len <= '0;
          end
          if (tap == TAP_MAX) begin
            state <= S_FINISH;
          end else begin
            tap   <= tap + TAP_ONE;
            state <= S_SET;
          end
        end
        S_FINISH: begin
          if (best_len != '0) begin
            win_lo_o    <= best_start;
            win_hi_o    <= hi_c;
            delay_cfg_o <= W'(sum_c >> 1);
            error_o     <= 1'b0;
          end else begin
            win_lo_o    <= '0;
            win_hi_o    <= '0;
            delay_cfg_o <= TAP_DEF;
            error_o     <= 1'b1;
          end
          done_o <= 1'b1;
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rpc_dqs_calib_ctrl.sv
// tb_rpc_dqs_calib_ctrl: directed bench for the DQS calibration sequencer.
// A training responder acks two cycles after req; pass taps come from a mask.
module tb_rpc_dqs_calib_ctrl;

  localparam logic [31:0] PAT = 32'hA5A5_5A5A;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [31:0] expected_i = '0;
  logic        trn_req_o;
  logic        trn_ack_i = 1'b0;
  logic [31:0] trn_data_i = '0;
  logic [4:0]  delay_cfg_o;
  logic        busy_o;
  logic        done_o;
  logic        error_o;
  logic [4:0]  win_lo_o;
  logic [4:0]  win_hi_o;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] mask = '0;
  logic        resp_en = 1'b1;
  int          rcnt = 0;

  always #5 clk = ~clk;

  rpc_dqs_calib_ctrl dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .expected_i (expected_i),
    .trn_req_o  (trn_req_o),
    .trn_ack_i  (trn_ack_i),
    .trn_data_i (trn_data_i),
    .delay_cfg_o(delay_cfg_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .error_o    (error_o),
    .win_lo_o   (win_lo_o),
    .win_hi_o   (win_hi_o)
  );

  always @(negedge clk) begin
    if (resp_en && trn_req_o && !trn_ack_i) begin
      rcnt = rcnt + 1;
      if (rcnt == 2) begin
        trn_ack_i  = 1'b1;
        trn_data_i = mask[delay_cfg_o] ? PAT : 32'h0;
      end
    end else begin
      trn_ack_i = 1'b0;
      rcnt      = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rng(input int lo, input int hi);
    logic [31:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic pulse_start(input logic [31:0] e);
    @(negedge clk);
    start_i    = 1'b1;
    expected_i = e;
    @(negedge clk);
    start_i    = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int i;
    i = 0;
    while (!done_o && i < budget) begin
      @(negedge clk);
      i++;
    end
    check({tag, " done"}, {31'd0, done_o}, 32'd1);
  endtask

  task automatic run(input string tag, input logic [31:0] m,
                     input logic er, input int lo, input int hi,
                     input int cfg);
    mask = m;
    pulse_start(PAT);
    check({tag, " busy_rise"}, {31'd0, busy_o}, 32'd1);
    check({tag, " done_clr"}, {31'd0, done_o}, 32'd0);
    wait_done(tag, 2000);
    check({tag, " error"}, {31'd0, error_o}, {31'd0, er});
    check({tag, " win_lo"}, {27'd0, win_lo_o}, lo);
    check({tag, " win_hi"}, {27'd0, win_hi_o}, hi);
    check({tag, " cfg"}, {27'd0, delay_cfg_o}, cfg);
    check({tag, " busy_fall"}, {31'd0, busy_o}, 32'd0);
  endtask

  initial begin
    int c;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    check("rst cfg", {27'd0, delay_cfg_o}, 32'd16);
    check("rst req", {31'd0, trn_req_o}, 32'd0);
    check("rst busy", {31'd0, busy_o}, 32'd0);
    check("rst done", {31'd0, done_o}, 32'd0);
    check("rst error", {31'd0, error_o}, 32'd0);
    check("rst win_lo", {27'd0, win_lo_o}, 32'd0);
    check("rst win_hi", {27'd0, win_hi_o}, 32'd0);

    run("all_pass", 32'hFFFF_FFFF, 1'b0, 0, 31, 15);
    run("win10_20", rng(10, 20), 1'b0, 10, 20, 15);
    run("two_win", rng(3, 5) | rng(20, 27), 1'b0, 20, 27, 23);
    run("tie", rng(2, 4) | rng(10, 12), 1'b0, 2, 4, 3);
    run("no_pass", 32'h0, 1'b1, 0, 0, 16);

    resp_en = 1'b0;
    pulse_start(PAT);
    c = 0;
    while (!trn_req_o && c < 50) begin
      @(negedge clk);
      c++;
    end
    check("to req_seen", {31'd0, trn_req_o}, 32'd1);
    c = 0;
    while (trn_req_o && c < 3000) begin
      c++;
      @(negedge clk);
    end
    check("to req_len", c, 32'd1024);
    wait_done("to", 20);
    check("to error", {31'd0, error_o}, 32'd1);
    check("to cfg", {27'd0, delay_cfg_o}, 32'd16);
    resp_en = 1'b1;

    mask = 32'hFFFF_FFFF;
    pulse_start(PAT);
    c = 0;
    while (!(trn_req_o && delay_cfg_o == 5'd7) && c < 500) begin
      @(negedge clk);
      c++;
    end
    check("rstmid tap7_req", {31'd0, trn_req_o}, 32'd1);
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    check("rstmid req", {31'd0, trn_req_o}, 32'd0);
    check("rstmid busy", {31'd0, busy_o}, 32'd0);
    check("rstmid cfg", {27'd0, delay_cfg_o}, 32'd16);
    check("rstmid error", {31'd0, error_o}, 32'd0);
    @(negedge clk);
    rst_i = 1'b0;

    pulse_start(PAT);
    repeat (40) @(negedge clk);
    pulse_start(32'h0);
    check("ign busy1", {31'd0, busy_o}, 32'd1);
    repeat (100) @(negedge clk);
    pulse_start(32'h1234_5678);
    check("ign busy2", {31'd0, busy_o}, 32'd1);
    wait_done("ign", 2000);
    check("ign error", {31'd0, error_o}, 32'd0);
    check("ign win_lo", {27'd0, win_lo_o}, 32'd0);
    check("ign win_hi", {27'd0, win_hi_o}, 32'd31);
    check("ign cfg", {27'd0, delay_cfg_o}, 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rpc_dqs_calib_ctrl.md
Name: rpc_dqs_calib_ctrl

Overview:
Calibration sequencer for the RPC PHY read-capture delay line. On request it sweeps the DQS delay tap from 0 to max. At each tap it issues one training read through a req/ack handshake to the RPC controller and compares the returned word against an expected pattern. It then programs the centre of the longest contiguous passing window into the delay configuration. It sits between the register file (start/pattern/status) and the PHY delay-config input.

Parameters:
DELAY_CFG_WIDTH, 5, width of the delay tap code; taps 0..2^W-1
PATTERN_WIDTH, 32, width of the training data word
SETTLE_CYCLES, 8, cycles waited after a tap change before the training read (>=1)
TIMEOUT_CYCLES, 1024, maximum cycles waiting for trn_ack_i
DEFAULT_TAP, 16, tap driven after reset and after a failed calibration

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
start_i  in  1  single-cycle pulse that starts calibration; ignored while busy_o=1
expected_i  in  PATTERN_WIDTH  expected training word; sampled on accepted start_i
trn_req_o  out  1  training read request; held high until acknowledged
trn_ack_i  in  1  one-cycle acknowledge; trn_data_i is valid in the same cycle
trn_data_i  in  PATTERN_WIDTH  captured training word
delay_cfg_o  out  DELAY_CFG_WIDTH  tap code driven to the PHY delay line
busy_o  out  1  calibration in progress
done_o  out  1  level; calibration finished; cleared on next accepted start_i
error_o  out  1  level; last calibration failed (no pass, or timeout)
win_lo_o  out  DELAY_CFG_WIDTH  first tap of the best window (0 on error)
win_hi_o  out  DELAY_CFG_WIDTH  last tap of the best window (0 on error)

Behaviour:
- Interface: one clock (clk_i); reset rst_i is synchronous and active-high.
- Reset values: delay_cfg_o=DEFAULT_TAP; trn_req_o, busy_o, done_o, error_o = 0; win_lo_o = win_hi_o = 0. FSM goes to IDLE and all counters clear. Reset mid-sweep aborts immediately; no pending request survives.
- FSM states: IDLE, SET, SETTLE, REQ, EVAL, FINISH.
- IDLE: on start_i, latch expected_i, clear done_o, error_o and the window trackers, set tap=0, go to SET; busy_o=1 from the next cycle.
- SET: delay_cfg_o<=tap, go to SETTLE.
- SETTLE: count SETTLE_CYCLES cycles, then go to REQ.
- REQ: trn_req_o=1. trn_req_o stays high while trn_ack_i=0.
  - On the trn_ack_i cycle: deassert trn_req_o the next cycle, register pass=(trn_data_i==expected), go to EVAL.
  - A waiting-cycle counter runs in REQ. If it reaches TIMEOUT_CYCLES without ack: drop trn_req_o, set error_o, go to FINISH with fail semantics.
  - A trn_ack_i seen outside REQ is ignored.
- EVAL:
  - Pass: if cur_len==0 then cur_start=tap; cur_len+=1. If the new cur_len > best_len, then best_start=cur_start and best_len=cur_len. Strictly greater, so the first window wins ties.
  - Fail: cur_len=0.
  - If tap==max go to FINISH, else tap+=1 and go to SET.
  - cur_len and best_len are DELAY_CFG_WIDTH+1 bits wide; no wrap.
- FINISH:
  - best_len>0: win_lo_o=best_start, win_hi_o=best_start+best_len-1, delay_cfg_o=(win_lo_o+win_hi_o)>>1 (floor, computed at DELAY_CFG_WIDTH+1 bits), error_o=0.
  - best_len==0 or timeout: delay_cfg_o=DEFAULT_TAP, error_o=1, win_lo_o=win_hi_o=0.
  - done_o=1, busy_o=0, return to IDLE.
- Latency per tap: 1 (SET) + SETTLE_CYCLES + (handshake cycles, >=1) + 1 (EVAL). Full sweep is 2^W times that, plus 1 for FINISH.
- Simultaneous start_i and FINISH: start_i is ignored because busy_o is still 1.
- trn_data_i is sampled only in the trn_ack_i cycle while in REQ.

Test Plan:
- Responder always returns expected=0xA5A5_5A5A, ack 2 cycles after req -> window 0..31, delay_cfg_o=15, done_o=1, error_o=0.
- Pass only at taps 10..20 -> win_lo=10, win_hi=20, delay_cfg_o=15.
- Pass at taps 3..5 and 20..27 -> win 20..27, delay_cfg_o=23; with ties 2..4 and 10..12 -> win 2..4, delay_cfg_o=3.
- All taps mismatch (data=0) -> error_o=1, delay_cfg_o=16, win 0..0, busy_o falls after tap 31.
- Ack never asserted at tap 0 -> trn_req_o high exactly 1024 cycles, then error_o=1, delay_cfg_o=16, done_o=1.
- rst_i asserted during REQ at tap 7 -> next cycle trn_req_o=0, busy_o=0, delay_cfg_o=16. Then a new start_i runs a full sweep; start_i pulses issued mid-sweep are ignored.
